// File: rtl/multiword_add_ctrl.sv
// Sequencer that chains an external combinational N-bit adder across several
// beats to add or subtract multi-word operands, least-significant word first.
`ifndef N
`define N 8
`endif

module multiword_add_ctrl #(
  parameter int N         = `N,
  parameter int MAX_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         in_sub,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_last,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic           r_carry_q;
  logic           r_sub_q;
  logic           r_out_valid;
  logic [N-1:0]   r_out_sum;
  logic           r_out_last;
  logic           r_out_cout;
  logic           r_out_ovf;
  logic           r_err;

  logic           w_accept;
  logic           w_first_beat;
  logic           w_sub_eff;
  logic [N-1:0]   w_add_b;
  logic           w_add_cin;
  logic [CW-1:0]  w_cnt_now;
  logic           w_force_last;
  logic           w_eff_last;
  logic           w_proto_err;
  logic           w_ovf;

  // One-deep output register: ready passes straight through when it drains.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = w_eff_last ? S_IDLE : S_BUSY;
  end

  // Output / decode logic. A first flag in BUSY restarts the operation, so it
  // is a first beat just like any beat arriving in IDLE.
  always_comb begin
    w_first_beat = (r_state == S_IDLE) || in_first;
    w_sub_eff    = w_first_beat ? in_sub : r_sub_q;
    w_add_b      = in_b ^ {N{w_sub_eff}};
    w_add_cin    = w_first_beat ? w_sub_eff : r_carry_q;
    w_cnt_now    = w_first_beat ? '0 : r_cnt;
    w_force_last = !in_last && (w_cnt_now == CW'(MAX_WORDS - 1));
    w_eff_last   = in_last || w_force_last;
    w_proto_err  = ((r_state == S_IDLE) && !in_first) ||
                   ((r_state == S_BUSY) && in_first)  ||
                   w_force_last;
    w_ovf        = (in_a[N-1] == w_add_b[N-1]) && (add_sum[N-1] != in_a[N-1]);
  end

  assign add_a   = in_a;
  assign add_b   = w_add_b;
  assign add_cin = w_add_cin;

  // Beat bookkeeping: carry chain, latched mode, and beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_carry_q <= 1'b0;
      r_sub_q   <= 1'b0;
    end else if (w_accept) begin
      r_carry_q <= add_cout;
      if (w_first_beat) r_sub_q <= in_sub;
      if (w_eff_last)        r_cnt <= '0;
      else if (w_first_beat) r_cnt <= CW'(1);
      else                   r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result register; a simultaneous drain and accept keeps it full with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= add_sum;
      r_out_last  <= w_eff_last;
      r_out_cout  <= w_eff_last && add_cout;
      r_out_ovf   <= w_eff_last && w_ovf;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_err <= 1'b0;
    else if (w_accept && w_proto_err) r_err <= 1'b1;
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_last  = r_out_last;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign err       = r_err;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Bench for multiword_add_ctrl: models the external adder, checks every output
// word against wide-integer arithmetic on whole operands.
module tb_multiword_add_ctrl;

  localparam int N  = 8;
  localparam int MW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic         in_sub = 1'b0;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_last;
  logic         out_cout;
  logic         out_ovf;
  logic         err;

  logic tb_ready   = 1'b1;
  logic rand_ready = 1'b0;
  logic rr         = 1'b1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] sum;
    logic         last;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t q[$];

  multiword_add_ctrl #(.N(N), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last),
    .out_cout(out_cout), .out_ovf(out_ovf), .err(err)
  );

  // The external adder the block drives.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign out_ready = rand_ready ? rr : tb_ready;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rr = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  // Scoreboard: every output handshake must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output sum=%h last=%b (no word expected)", out_sum, out_last);
      end else begin
        e = q.pop_front();
        if (out_sum !== e.sum || out_last !== e.last || out_cout !== e.cout || out_ovf !== e.ovf) begin
          bad++;
          $display("FAIL out_word got sum=%h last=%b cout=%b ovf=%b want sum=%h last=%b cout=%b ovf=%b",
                   out_sum, out_last, out_cout, out_ovf, e.sum, e.last, e.cout, e.ovf);
        end
      end
    end
  end

  // Reference: whole-operand arithmetic, then split into words.
  task automatic push_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint unsigned mask, ua, ub, r;
    longint sa, sb, res, lim;
    logic cout, ovf;
    exp_t e;
    mask = (64'd1 << (8 * k)) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    r    = sub ? (ua + ((~ub) & mask) + 64'd1) : (ua + ub);
    cout = ((r >> (8 * k)) & 64'd1) != 64'd0;
    lim  = longint'(64'd1 << (8 * k - 1));
    sa   = ((ua >> (8 * k - 1)) & 64'd1) != 0 ? longint'(ua) - 2 * lim : longint'(ua);
    sb   = ((ub >> (8 * k - 1)) & 64'd1) != 0 ? longint'(ub) - 2 * lim : longint'(ub);
    res  = sub ? sa - sb : sa + sb;
    ovf  = (res >= lim) || (res < -lim);
    for (int i = 0; i < k; i++) begin
      e.sum  = 8'(r >> (8 * i));
      e.last = (i == k - 1);
      e.cout = e.last && cout;
      e.ovf  = e.last && ovf;
      q.push_back(e);
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic sub,
                           input logic first, input logic last, output int waited);
    bit ok = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_first = first; in_last = last;
    waited = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      waited++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout waited=%0d want accept within 300 cycles", waited);
    end
  endtask

  task automatic send_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic sub);
    int w;
    push_op(k, a, b, sub);
    for (int i = 0; i < k; i++)
      send_beat(a[8*i +: 8], b[8*i +: 8], sub, i == 0, i == k - 1, w);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 300; c++) begin
      if (q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    total++;
    if (q.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL %s_drain pending=%0d out_valid=%b want pending=0 out_valid=0", name, q.size(), out_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_sum, out_last, out_cout, out_ovf, err} !== {1'b0, 8'h00, 4'b0000}) begin
      bad++;
      $display("FAIL reset_outputs got v=%b s=%h l=%b c=%b o=%b e=%b want all zero",
               out_valid, out_sum, out_last, out_cout, out_ovf, err);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    send_op(1, 32'hFF, 32'h01, 1'b0);       // 0xFF+0x01 wraps with carry
    send_op(2, 32'h01FF, 32'h0001, 1'b0);   // carry chains into word 1
    send_op(1, 32'h05, 32'h07, 1'b1);       // borrow
    send_op(1, 32'h80, 32'h01, 1'b1);       // signed overflow
    wait_drain("directed");
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL directed_err got %b want 0", err);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] held;
    int w;
    push_op(3, 32'h00_12_34, 32'h00_56_78, 1'b0);
    tb_ready = 1'b0;
    send_beat(8'h34, 8'h78, 1'b0, 1'b1, 1'b0, w);
    held = out_sum;
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h56; in_first = 1'b0; in_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_sum !== held || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold got rdy=%b sum=%h v=%b want rdy=0 sum=%h v=1", in_ready, out_sum, out_valid, held);
      end
    end
    @(posedge clk); #1;
    tb_ready = 1'b1;
    send_beat(8'h12, 8'h56, 1'b0, 1'b0, 1'b0, w);
    total++;
    if (w != 0) begin bad++; $display("FAIL release_beat1 waited=%0d want 0", w); end
    send_beat(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, w);
    total++;
    if (w != 0) begin bad++; $display("FAIL release_beat2 waited=%0d want 0", w); end
    wait_drain("backpressure");
  endtask

  task automatic test_random;
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++)
      send_op($urandom_range(1, MW), $urandom, $urandom, 1'($urandom_range(0, 1)));
    rand_ready = 1'b0;
    tb_ready   = 1'b1;
    wait_drain("random");
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL random_err got %b want 0", err);
    end
  endtask

  task automatic test_overlong;
    int w;
    push_op(4, 32'hC0_80_F0_FF, 32'h50_90_20_01, 1'b0);
    send_beat(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, w);
    send_beat(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, w);
    send_beat(8'h80, 8'h90, 1'b0, 1'b0, 1'b0, w);
    send_beat(8'hC0, 8'h50, 1'b0, 1'b0, 1'b0, w);
    wait_drain("overlong");
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL overlong_err got %b want 1", err); end
    push_op(1, 32'h33, 32'h44, 1'b0);
    send_beat(8'h33, 8'h44, 1'b0, 1'b0, 1'b1, w);
    wait_drain("nofirst");
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL sticky_err got %b want 1", err); end
  endtask

  task automatic test_reset_mid;
    int w;
    tb_ready = 1'b0;
    send_beat(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, w);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_sum !== 8'h00 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got v=%b sum=%h err=%b want v=0 sum=00 err=0", out_valid, out_sum, err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tb_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01; in_sub = 1'b0; in_first = 1'b1; in_last = 1'b1;
    #1;
    total++;
    if (add_cin !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL fresh_cin got cin=%b v=%b want cin=0 v=0", add_cin, out_valid);
    end
    push_op(1, 32'h01, 32'h01, 1'b0);
    send_beat(8'h01, 8'h01, 1'b0, 1'b1, 1'b1, w);
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_overlong();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 The block SHALL have parameter N, default `N from params.vh, the word width of one beat and of the attached adder.
REQ-002 The block SHALL have parameter MAX_WORDS, default 4, the maximum beats per operation (>=1).
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1, operand beat valid.
REQ-006 The block SHALL have port in_ready, output, 1, beat accepted when in_valid && in_ready.
REQ-007 The block SHALL have ports in_a and in_b, input, N each, operand words, least-significant word first.
REQ-008 The block SHALL have port in_first, input, 1, marking the first beat of an operation.
REQ-009 The block SHALL have port in_last, input, 1, marking the last beat of an operation.
REQ-010 The block SHALL have port in_sub, input, 1, subtract mode, sampled on first beats only.
REQ-011 The block SHALL have ports add_a and add_b, output, N each, and add_cin, output, 1, which drive an external combinational N-bit adder.
REQ-012 The block SHALL have ports add_sum, input, N, and add_cout, input, 1, returned from that adder in the same cycle.
REQ-013 The block SHALL have ports out_valid, output, 1, and out_ready, input, 1, the result handshake.
REQ-014 The block SHALL have ports out_sum, output, N, and out_last, output, 1, the result word and its last-beat flag.
REQ-015 The block SHALL have ports out_cout and out_ovf, output, 1 each, the final carry and signed overflow, meaningful when out_last=1.
REQ-016 The block SHALL have port err, output, 1, a sticky protocol-error flag.

Function
REQ-017 in_ready SHALL equal !out_valid || out_ready (one-deep output register, combinational pass-through of ready).
REQ-018 add_a SHALL equal in_a, and add_b SHALL equal in_b XOR {N{sub_eff}}, where sub_eff is in_sub on a first beat and the latched sub_q otherwise.
REQ-019 add_cin SHALL equal sub_eff on a beat treated as first, and carry_q otherwise.
REQ-020 On accept, the block SHALL register out_sum<=add_sum, out_last<=in_last, carry_q<=add_cout, and out_valid<=1 (latency one cycle).
REQ-021 On accept with in_last=1, the block SHALL register out_cout<=add_cout and out_ovf<=(add_a[N-1]==add_b[N-1]) && (add_sum[N-1]!=add_a[N-1]); on other beats out_cout and out_ovf SHALL be 0.
REQ-022 out_valid SHALL clear when out_valid && out_ready and there is no accept in the same cycle; a simultaneous accept SHALL keep out_valid=1 with the new data.
REQ-023 The state machine SHALL have states IDLE and BUSY, plus beat counter cnt (0..MAX_WORDS).
REQ-024 IDLE: an accepted beat SHALL be treated as first (latch sub_q, cnt<=1); if in_first=0, err SHALL set; in_last=1 SHALL stay in IDLE, otherwise go to BUSY.
REQ-025 BUSY: an accepted beat with in_first=1 SHALL set err and restart the operation as a first beat (cnt<=1, carry ignored).
REQ-026 BUSY: an accepted beat with in_last=1 SHALL go to IDLE; otherwise cnt SHALL increment.
REQ-027 BUSY: an accepted beat when cnt==MAX_WORDS-1 and in_last=0 SHALL set err and be forced as last (out_last=1, go to IDLE).
REQ-028 A single beat with in_first=in_last=1 SHALL be a complete N-bit operation.
REQ-029 err SHALL remain set until reset; no other clear.
REQ-030 While out_valid=1 and out_ready=0, out_* SHALL hold stable and no beat SHALL be accepted.

Reset
REQ-031 While rst_n=0: out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, err=0, carry_q=0, sub_q=0, cnt=0, state=IDLE.
REQ-032 Reset asserted mid-operation SHALL abort it; any pending output word is discarded and the next beat starts a new operation.

Verification
REQ-033 N=8: one beat, first=last=1, sub=0, A=0xFF, B=0x01 -> next cycle out_sum=0x00, out_cout=1, out_ovf=0, out_last=1.
REQ-034 N=8, 2 beats, sub=0, A=0x01_FF, B=0x00_01 -> beat0 out_sum=0x00, beat1 out_sum=0x02, out_cout=0 (carry chained).
REQ-035 N=8, one beat, sub=1, A=0x05, B=0x07 -> out_sum=0xFE, out_cout=0 (borrow); A=0x80, B=0x01 -> out_sum=0x7F, out_ovf=1.
REQ-036 out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, out_sum stable; releasing it -> beats drain back-to-back at one per cycle with no loss.
REQ-037 MAX_WORDS=4, 4 beats without in_last -> 4th output has out_last=1 and err=1; next beat with in_first=0 from IDLE -> err stays 1.
REQ-038 rst_n pulsed low after beat 1 of 3 -> out_valid=0 immediately; a new first beat then produces a fresh sum with add_cin=0.
